// File: rtl/digit_entry_ctrl_pkg.sv
// Shared definitions for the digit entry controller: FSM encoding, button
// indices, the 7-segment pattern table and the digit stepping helpers.
package digit_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam int BTN_INC   = 0;
  localparam int BTN_DEC   = 1;
  localparam int BTN_CLR   = 2;
  localparam int BTN_ENTER = 3;
  localparam int NUM_BTNS  = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the blank cell.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1111111,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  // Stepping never lands on blank: up wraps 9->1, down wraps 1->9 (and 0->9).
  function automatic logic [3:0] step_up(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd1 : d + 4'd1;
  endfunction

  function automatic logic [3:0] step_down(input logic [3:0] d);
    return ((d <= 4'd1) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit to active-low 7-segment decode; out-of-range codes blank.
module seg7_decode
  import digit_entry_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Single-digit entry controller: synchronized button edges, digit stepping with
// auto-repeat, and a commit/reject handshake toward a downstream segment register.
module digit_entry_ctrl
  import digit_entry_ctrl_pkg::*;
#(
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       clr_btn,
  input  logic       enter_btn,
  input  logic       locked,
  output logic [3:0] digit,
  output logic [6:0] seg_out,
  output logic       load,
  output logic       reject
);

  localparam int CNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] sync1_reg;
  logic [NUM_BTNS-1:0] sync2_reg;
  logic [NUM_BTNS-1:0] prev_reg;
  logic [NUM_BTNS-1:0] press;

  state_t state_reg;
  state_t state_next;

  logic [3:0]       digit_reg;
  logic [3:0]       digit_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             reject_reg;
  logic             reject_next;
  logic             rep_fire;
  logic             step_inc;
  logic             step_dec;

  assign btn_raw = {enter_btn, clr_btn, dec_btn, inc_btn};

  // Two-flop synchronizer followed by edge history for each button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_edge
      assign press[gi] = sync2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (press[BTN_ENTER]) begin
          state_next = locked ? WAIT_REL : COMMIT;
        end
      end
      COMMIT: begin
        state_next = WAIT_REL;
      end
      WAIT_REL: begin
        if (!sync2_reg[BTN_ENTER]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    load = 1'b0;
    if (state_reg == COMMIT) begin
      load = 1'b1;
    end
  end

  // Repeat counter runs only while exactly one of inc/dec is held in a stable IDLE.
  always_comb begin
    cnt_next = '0;
    rep_fire = 1'b0;
    if ((state_reg == IDLE) && (state_next == IDLE) &&
        (sync2_reg[BTN_INC] ^ sync2_reg[BTN_DEC])) begin
      if (cnt_reg == CNT_LAST) begin
        rep_fire = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign step_inc = press[BTN_INC] | (rep_fire & sync2_reg[BTN_INC]);
  assign step_dec = press[BTN_DEC] | (rep_fire & sync2_reg[BTN_DEC]);

  always_comb begin
    digit_next = digit_reg;
    if (state_reg == IDLE) begin
      if (press[BTN_ENTER]) begin
        digit_next = digit_reg;
      end else if (press[BTN_CLR]) begin
        digit_next = 4'd0;
      end else if (step_inc && !step_dec) begin
        digit_next = step_up(digit_reg);
      end else if (step_dec && !step_inc) begin
        digit_next = step_down(digit_reg);
      end
    end
  end

  assign reject_next = (state_reg == IDLE) && press[BTN_ENTER] && locked;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_reg  <= 4'd0;
      cnt_reg    <= '0;
      reject_reg <= 1'b0;
    end else begin
      digit_reg  <= digit_next;
      cnt_reg    <= cnt_next;
      reject_reg <= reject_next;
    end
  end

  assign digit  = digit_reg;
  assign reject = reject_reg;

  seg7_decode u_seg7_decode (
    .digit (digit_reg),
    .seg   (seg_out)
  );

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Directed bench for digit_entry_ctrl: stepping, clear, commit, reject,
// auto-repeat, press priority and reset behaviour.
module tb_digit_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       enter_btn = 1'b0;
  logic       locked = 1'b0;
  logic [3:0] digit;
  logic [6:0] seg_out;
  logic       load;
  logic       reject;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_ref [10];
  logic [3:0] exp_d;
  logic [6:0] lseg;
  int         lc;
  int         rc;
  int         lcyc;
  int         rcyc;

  always #5 clk = ~clk;

  digit_entry_ctrl #(
    .REPEAT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inc_btn   (inc_btn),
    .dec_btn   (dec_btn),
    .clr_btn   (clr_btn),
    .enter_btn (enter_btn),
    .locked    (locked),
    .digit     (digit),
    .seg_out   (seg_out),
    .load      (load),
    .reject    (reject)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       inc_btn = v;
      1:       dec_btn = v;
      2:       clr_btn = v;
      default: enter_btn = v;
    endcase
  endtask

  // Hold for 3 cycles (below the repeat period), then release and let it settle.
  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    repeat (3) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    seg_ref = '{7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(digit), 32'(4'd0));
    check("rst_seg", 32'(seg_out), 32'(7'b1111111));
    check("rst_load", 32'(load), 32'(1'b0));
    check("rst_reject", 32'(reject), 32'(1'b0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Ten inc presses: 1..9 then wrap to 1
    for (int i = 1; i <= 10; i++) begin
      press_btn(0);
      exp_d = (i == 10) ? 4'd1 : 4'(i);
      check("inc_seq_digit", 32'(digit), 32'(exp_d));
      check("inc_seq_seg", 32'(seg_out), 32'(seg_ref[exp_d]));
    end
    check("inc_final_seg", 32'(seg_out), 32'(7'b1111001));

    // Dec wrap 1->9, then 9->8
    press_btn(1);
    check("dec_wrap_1_9", 32'(digit), 32'(4'd9));
    press_btn(1);
    check("dec_9_8", 32'(digit), 32'(4'd8));

    // Reset, dec from blank, then clear
    do_reset();
    check("rst2_digit", 32'(digit), 32'(4'd0));
    press_btn(1);
    check("dec_0_9", 32'(digit), 32'(4'd9));
    check("dec_0_9_seg", 32'(seg_out), 32'(7'b0010000));
    press_btn(2);
    check("clr_digit", 32'(digit), 32'(4'd0));
    check("clr_seg", 32'(seg_out), 32'(7'b1111111));

    // Digit 5, enter held 20 cycles with inc presses during the hold
    for (int i = 0; i < 5; i++) press_btn(0);
    check("setup5", 32'(digit), 32'(4'd5));
    lc = 0; rc = 0; lcyc = 0; lseg = 7'b0;
    enter_btn = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (load === 1'b1) begin lc++; lseg = seg_out; lcyc = i; end
      if (reject === 1'b1) rc++;
      if (i == 5 || i == 11) inc_btn = 1'b1;
      if (i == 8 || i == 14) inc_btn = 1'b0;
      if (i == 20) enter_btn = 1'b0;
    end
    check("commit_load_count", 32'(lc), 32'(1));
    check("commit_load_cycle", 32'(lcyc), 32'(3));
    check("commit_seg", 32'(lseg), 32'(7'b0010010));
    check("commit_no_reject", 32'(rc), 32'(0));
    check("commit_digit_kept", 32'(digit), 32'(4'd5));

    // Locked enter: one reject pulse, no load
    locked = 1'b1;
    lc = 0; rc = 0; rcyc = 0;
    enter_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (load === 1'b1) lc++;
      if (reject === 1'b1) begin rc++; rcyc = i; end
      if (i == 3) enter_btn = 1'b0;
    end
    locked = 1'b0;
    check("reject_count", 32'(rc), 32'(1));
    check("reject_cycle", 32'(rcyc), 32'(3));
    check("reject_no_load", 32'(lc), 32'(0));
    check("reject_digit_kept", 32'(digit), 32'(4'd5));
    press_btn(0);
    check("after_reject_inc", 32'(digit), 32'(4'd6));

    // Auto-repeat: inc held 13 cycles after synchronization from blank
    press_btn(2);
    check("repeat_start", 32'(digit), 32'(4'd0));
    inc_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("repeat_press_step", 32'(digit), 32'(4'd1));
    repeat (2) @(negedge clk);
    check("repeat_not_early", 32'(digit), 32'(4'd1));
    @(negedge clk);
    check("repeat_first", 32'(digit), 32'(4'd2));
    repeat (7) @(negedge clk);
    inc_btn = 1'b0;
    check("repeat_second", 32'(digit), 32'(4'd3));
    @(negedge clk);
    check("repeat_third", 32'(digit), 32'(4'd4));
    repeat (6) @(negedge clk);
    check("repeat_final", 32'(digit), 32'(4'd4));

    // inc and dec together: no change
    inc_btn = 1'b1; dec_btn = 1'b1;
    repeat (6) @(negedge clk);
    inc_btn = 1'b0; dec_btn = 1'b0;
    repeat (4) @(negedge clk);
    check("inc_dec_same", 32'(digit), 32'(4'd4));

    // inc and enter together: enter wins, load carries old digit
    lc = 0; lseg = 7'b0;
    inc_btn = 1'b1; enter_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (load === 1'b1) begin lc++; lseg = seg_out; end
      if (i == 3) begin inc_btn = 1'b0; enter_btn = 1'b0; end
    end
    check("inc_enter_loads", 32'(lc), 32'(1));
    check("inc_enter_seg", 32'(lseg), 32'(7'b0011001));
    check("inc_enter_digit", 32'(digit), 32'(4'd4));

    // Reset during COMMIT drops load at once; no load after release
    enter_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("commit_reached", 32'(load), 32'(1'b1));
    #1 reset = 1'b0;
    #1;
    check("rst_in_commit_load", 32'(load), 32'(1'b0));
    check("rst_in_commit_digit", 32'(digit), 32'(4'd0));
    check("rst_in_commit_seg", 32'(seg_out), 32'(7'b1111111));
    enter_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (load === 1'b1) lc++;
    end
    check("no_load_after_rst", 32'(lc), 32'(0));

    // Button held through reset release counts as one press
    @(negedge clk);
    reset = 1'b0;
    inc_btn = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("held_at_release", 32'(digit), 32'(4'd1));
    inc_btn = 1'b0;
    repeat (4) @(negedge clk);
    check("held_single_press", 32'(digit), 32'(4'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_entry_ctrl.md
DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 The block SHALL have parameter REPEAT_CYCLES, default 12_500_000, meaning the clk cycles a held inc/dec button waits before each auto-repeat step (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port inc_btn, input, 1 bit: raw asynchronous button level, high = pressed, increments the digit.
REQ-005 The block SHALL have port dec_btn, input, 1 bit: raw asynchronous button level, high = pressed, decrements the digit.
REQ-006 The block SHALL have port clr_btn, input, 1 bit: raw asynchronous button level, high = pressed, blanks the digit.
REQ-007 The block SHALL have port enter_btn, input, 1 bit: raw asynchronous button level, high = pressed, commits the digit.
REQ-008 The block SHALL have port locked, input, 1 bit: the selected cell is a given clue; commits are refused while high.
REQ-009 The block SHALL have port digit, output, 4 bits: current edit value, 0 = blank, 1..9 = digit.
REQ-010 The block SHALL have port seg_out, output, 7 bits: active-low segments {g,f,e,d,c,b,a} of digit, for the downstream load register data input.
REQ-011 The block SHALL have port load, output, 1 bit: a one-cycle strobe telling the downstream register to capture seg_out.
REQ-012 The block SHALL have port reject, output, 1 bit: a one-cycle strobe marking an enter press refused because locked was high.

Function
REQ-013 Each button SHALL pass through a two-flop synchronizer and then a registered rising-edge detector; the press takes effect on the 3rd rising clk edge after the raw level is first sampled high.
REQ-014 The FSM SHALL have exactly three states: IDLE, COMMIT and WAIT_REL.
REQ-015 In IDLE, an inc press SHALL step digit 0->1, 1->2 … 8->9, and 9->1 (wrap-around; blank is never reached by stepping).
REQ-016 In IDLE, a dec press SHALL step digit 0->9, 9->8 … 2->1, and 1->9.
REQ-017 In IDLE, a clr press SHALL set digit to 0.
REQ-018 In IDLE, an enter press with locked=0 SHALL go to COMMIT with digit unchanged.
REQ-019 In IDLE, an enter press with locked=1 SHALL assert reject for exactly 1 cycle and go to WAIT_REL.
REQ-020 Simultaneous press priority SHALL be enter > clr > (inc,dec); if inc and dec are pressed in the same cycle, digit SHALL be unchanged.
REQ-021 Auto-repeat: while the synchronized inc (or dec) level stays high in IDLE, a cycle counter SHALL issue one extra step every REPEAT_CYCLES cycles; the counter SHALL clear on release, on a state change, or when both inc and dec are high.
REQ-022 In COMMIT, load=1 SHALL be asserted for exactly 1 cycle, and seg_out SHALL hold the committed pattern during that cycle; the next state SHALL be WAIT_REL.
REQ-023 In WAIT_REL, all presses SHALL be ignored and the repeat counter SHALL be held at 0; the FSM SHALL return to IDLE on the first cycle the synchronized enter level is low.
REQ-024 seg_out SHALL be a combinational decode of the registered digit, with 0->1111111 (blank), 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000 and 9->0010000; digit values 10..15 SHALL decode to 1111111.
REQ-025 load and reject SHALL never be asserted in the same cycle, and neither SHALL be asserted in two consecutive cycles.

Reset
REQ-026 On reset=0, the block SHALL immediately force digit=0, seg_out=1111111, load=0, reject=0, state=IDLE, synchronizers and edge history=0, and repeat counter=0.
REQ-027 A reset asserted during COMMIT SHALL drop load within the same cycle; no load pulse SHALL follow reset deassertion.
REQ-028 A button already held high at reset release SHALL register as one press once synchronized.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE, COMMIT, WAIT_REL), the SEG_BLANK constant (7'b1111111) and the 10-entry segment table.
REQ-030 The block SHALL instantiate one sub-module, seg7_decode (4-bit digit in, 7-bit active-low segments out), which the display path SHALL reuse.

Verification
REQ-031 Scenario: reset, then 10 inc presses -> digit sequence 1,2,…,9,1 and final seg_out=1111001.
REQ-032 Scenario: reset, 1 dec press, clr press -> digit=9 (seg_out 0010000), then digit=0 (seg_out 1111111).
REQ-033 Scenario: digit=5, locked=0, enter held 20 cycles -> exactly one load pulse with seg_out=0010010, and inc presses during the hold are ignored.
REQ-034 Scenario: locked=1, enter press -> reject high for 1 cycle, load never asserted, digit unchanged.
REQ-035 Scenario: REPEAT_CYCLES=4, inc held 13 cycles after synchronization from digit=0 -> digit=4 (1 press step plus 3 repeat steps).
REQ-036 Scenario: inc and dec pressed in the same cycle -> digit unchanged; inc and enter pressed together -> load fires with the old digit.
